eth_tx_arb: RTL

Frame-level round-robin arbiter that shares the single `eth_mac` transmit byte port (`tx_vld/tx_dat/tx_sof/tx_eof/tx_ack`) between NREQ independent frame sources (e.g. ARP responder, UDP engine, debug injector).

- It locks the grant from the first byte (SOF) to the acknowledged EOF byte, so frames are never interleaved.
- Bytes are forwarded without added latency while a grant is held.
- It sits in the `clk_mac` domain between the packet generators and `eth_mac`.

---
 rtl/eth_pkg.sv | 19 +
 rtl/rr_pick.sv | 26 ++
 rtl/eth_tx_arb.sv | 124 ++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: arbiter state encodings, limits and byte-bus widths.
package eth_pkg;

    localparam int ETH_ARB_MAX_REQ = 8;
    localparam int ETH_BYTE_W      = 8;

    typedef enum logic [0:0] {
        ETH_ARB_IDLE = 1'b0,
        ETH_ARB_XFER = 1'b1
    } eth_arb_state_t;

    typedef struct packed {
        logic                  vld;
        logic [ETH_BYTE_W-1:0] dat;
        logic                  sof;
        logic                  eof;
    } eth_byte_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning upward from ptr, wrapping at N.
module rr_pick #(
    parameter int N = 3,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);

    always_comb begin
        int j;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                idx   = W'(j);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_arb.sv
// Frame-level round-robin arbiter sharing the eth_mac tx byte port between NREQ sources.
module eth_tx_arb
    import eth_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int IW   = 3
) (
    input  logic                  clk_mac,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_vld,
    input  logic [8*NREQ-1:0]     req_dat,
    input  logic [NREQ-1:0]       req_sof,
    input  logic [NREQ-1:0]       req_eof,
    output logic [NREQ-1:0]       req_ack,
    output logic                  tx_vld,
    output logic [ETH_BYTE_W-1:0] tx_dat,
    output logic                  tx_sof,
    output logic                  tx_eof,
    input  logic                  tx_ack,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic                  drop,
    output logic                  proto_err
);

    eth_arb_state_t  state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic            first_q, first_d;
    logic            drop_q, drop_d;
    logic            perr_q, perr_d;
    logic [NREQ-1:0] cand, stale;
    logic [IW-1:0]   win;
    logic            found;
    logic            hit;
    eth_byte_t       sel;

    assign cand  = req_vld & req_sof;
    assign stale = req_vld & ~req_sof;

    rr_pick #(.N(NREQ), .W(IW)) u_pick (
        .req   (cand),
        .ptr   (ptr_q),
        .idx   (win),
        .found (found)
    );

    always_ff @(posedge clk_mac) begin
        if (rst) begin
            state_q <= ETH_ARB_IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            first_q <= 1'b0;
            drop_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            first_q <= first_d;
            drop_q  <= drop_d;
            perr_q  <= perr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        first_d = first_q;
        drop_d  = 1'b0;
        perr_d  = 1'b0;
        hit     = 1'b0;
        sel     = '0;
        req_ack = '0;
        grant   = '0;
        unique case (state_q)
            ETH_ARB_IDLE: begin
                if (found) begin
                    state_d = ETH_ARB_XFER;
                    gidx_d  = win;
                    ptr_d   = (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
                    first_d = 1'b1;
                end else begin
                    // Flush the lowest-indexed stale byte so its source cannot stall forever.
                    for (int i = 0; i < NREQ; i++) begin
                        if (stale[i] && !hit) begin
                            req_ack[i] = 1'b1;
                            hit        = 1'b1;
                        end
                    end
                    drop_d = hit;
                end
            end
            ETH_ARB_XFER: begin
                for (int i = 0; i < NREQ; i++) begin
                    if (gidx_q == IW'(i)) begin
                        sel.vld    = req_vld[i];
                        sel.dat    = req_dat[8*i +: 8];
                        sel.sof    = req_sof[i];
                        sel.eof    = req_eof[i];
                        grant[i]   = 1'b1;
                        req_ack[i] = tx_ack & req_vld[i];
                    end
                end
                if (tx_ack && sel.vld) begin
                    first_d = 1'b0;
                    perr_d  = sel.sof & ~first_q;
                    if (sel.eof) state_d = ETH_ARB_IDLE;
                end
            end
            default: state_d = ETH_ARB_IDLE;
        endcase
    end

    assign tx_vld    = sel.vld;
    assign tx_dat    = sel.dat;
    assign tx_sof    = sel.sof;
    assign tx_eof    = sel.eof;
    assign busy      = (state_q == ETH_ARB_XFER);
    assign drop      = drop_q;
    assign proto_err = perr_q;

endmodule
